cmd_stream_arbiter: RTL and testbench
=====================================

// Module: cmd_stream_arbiter
// PURPOSE
//  Round-robin arbiter sharing one valid/ready command stream among NUM_REQ requesters.
//  Bursts are atomic: a granted requester holds the stream until it sends a beat with last=1.
//  Output is registered (one stage) and feeds the downstream skid buffer / command FIFO.
//  Sits between the per-core command sources and the shared chip command path.
// PARAMETERS
//  NUM_REQ          4   number of requesters, >=2
//  FIFO_CMD_LENGTH  1   command word width in bits
//  ID_W             2   grant-id width, = max(1,$clog2(NUM_REQ)), localparam
// PORTS
//  clk      in   1                      rising-edge clock
//  reset    in   1                      synchronous, active-high reset
//  s_valid  in   NUM_REQ                per-requester valid
//  s_ready  out  NUM_REQ                per-requester ready; combinational, at most one bit set
//  s_data   in   NUM_REQ*FIFO_CMD_LENGTH  flattened; requester i at [i*W +: W]
//  s_last   in   NUM_REQ                per-requester end-of-burst flag
//  m_valid  out  1                      registered output valid
//  m_ready  in   1                      downstream ready
//  m_data   out  FIFO_CMD_LENGTH        registered command word
//  m_last   out  1                      registered end-of-burst flag
//  m_id     out  ID_W                   registered index of the source requester
// BEHAVIOUR
//  - Reset (sampled at clk edge while reset=1): state=IDLE, rr_ptr=0, grant=0, m_valid=0,
//    m_data=0, m_last=0, m_id=0. s_ready=0 while reset is high. Reset mid-burst drops the lock.
//  - ready = m_ready | ~m_valid. Output register loads only when ready=1.
//  - Transfer on requester i = s_valid[i] & s_ready[i]; output transfer = m_valid & m_ready.
//  - State IDLE: sel = first i with s_valid[i]=1 searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    s_ready[sel]=ready; all others 0. No valid -> all s_ready=0, state stays IDLE.
//  - State LOCK: s_ready[grant]=ready; all others 0 regardless of their valid.
//  - On an input transfer from i: m_data<=s_data[i], m_last<=s_last[i], m_id<=i, m_valid<=1.
//    If s_last[i]=0: grant<=i, state<=LOCK. If s_last[i]=1: state<=IDLE,
//    rr_ptr<=(i+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0).
//  - Ready with no input transfer: m_valid<=0 (data/last/id hold value, don't care).
//  - ready=0: output registers, state, grant and rr_ptr hold; s_ready all 0.
//  - Latency: accepted beat appears on m_* the next cycle. Full throughput of 1 beat/clk
//    while m_ready=1, including back-to-back bursts from different requesters.
//  - Single-beat burst (last=1 on first beat) never enters LOCK.
//  - LOCK with granted requester valid=0: stream idles, lock held, others starve (by design).
//  - rr_ptr updates only at burst end, so every requester is served within NUM_REQ bursts.
//  - m_valid/m_data/m_last/m_id must not change while m_valid=1 & m_ready=0.
// TESTING
//  1 Reset: reset=1 for 2 clk with all s_valid=1 -> s_ready=0000, m_valid=0, m_id=0.
//  2 RR fairness: all 4 valid, last=1 always, m_ready=1 -> m_id sequence 0,1,2,3,0,1...
//    one beat per cycle, no bubbles.
//  3 Burst lock: req1 sends 3 beats (last on 3rd) while req0,2 valid -> m_id=1,1,1 then 2;
//    s_ready[0]=s_ready[2]=0 during the burst.
//  4 Backpressure: m_ready=0 for 5 cycles mid-burst -> m_* stable, s_ready=0, no beat lost
//    or duplicated; data sequence 0xA,0xB,0xC preserved after release.
//  5 Wrap: rr_ptr=3, only req3 and req0 valid -> req3 served first, then req0 (ptr wraps to 0).
//  6 Reset mid-burst: reset during LOCK of req2 -> next cycle IDLE, rr_ptr=0, req0 granted first.

Source files
------------

// File: rtl/cmd_stream_arbiter.sv
// cmd_stream_arbiter
//   Round-robin arbiter that merges NUM_REQ valid/ready command streams into
//   one registered output stream. A requester that starts a burst keeps the
//   stream until it sends a beat with last=1, so bursts are never interleaved.
//   The round-robin pointer only moves at burst end. This guarantees that
//   every requester is served within NUM_REQ bursts.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   s_valid  per-requester valid
//   s_ready  per-requester ready (combinational, one-hot or zero)
//   s_data   flattened command words, requester i at [i*W +: W]
//   s_last   per-requester end-of-burst flag
//   m_valid  registered output valid
//   m_ready  downstream ready
//   m_data   registered command word
//   m_last   registered end-of-burst flag
//   m_id     registered index of the requester that sourced the beat
module cmd_stream_arbiter #(
  parameter  int NUM_REQ         = 4,
  parameter  int FIFO_CMD_LENGTH = 1,
  localparam int ID_W            = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 s_valid,
  output logic [NUM_REQ-1:0]                 s_ready,
  input  logic [NUM_REQ*FIFO_CMD_LENGTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]                 s_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [FIFO_CMD_LENGTH-1:0]         m_data,
  output logic                               m_last,
  output logic [ID_W-1:0]                    m_id
);

  localparam int W = FIFO_CMD_LENGTH;
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] sel;
  logic            sel_found;
  logic [ID_W:0]   idx;
  logic [ID_W-1:0] src;
  logic [ID_W-1:0] src_next;
  logic            ready;
  logic            xfer;

  logic [W-1:0] req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data[i] = s_data[i*W +: W];
  end

  // The output register can take a new beat when it is empty or draining.
  assign ready = m_ready | ~m_valid;

  // Round-robin search starting at rr_ptr. The loop walks backwards so
  // that the last assignment is the candidate closest to the pointer.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (s_valid[idx[ID_W-1:0]]) begin
        sel       = idx[ID_W-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // While locked, only the burst owner sees ready, even if it is idle.
  always_comb begin
    s_ready = '0;
    if (!reset) begin
      if (state_q == LOCK)  s_ready[grant_q] = ready;
      else if (sel_found)   s_ready[sel]     = ready;
    end
  end

  assign src      = (state_q == LOCK) ? grant_q : sel;
  assign xfer     = |(s_valid & s_ready);
  assign src_next = (src == LAST_IDX) ? '0 : src + 1'b1;

  // FSM next state: a beat without last opens or keeps a lock.
  always_comb begin
    state_d = state_q;
    if (xfer) state_d = s_last[src] ? IDLE : LOCK;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_id     <= '0;
    end else if (ready) begin
      m_valid <= xfer;
      if (xfer) begin
        m_data <= req_data[src];
        m_last <= s_last[src];
        m_id   <= src;
        if (s_last[src]) rr_ptr_q <= src_next;
        else             grant_q  <= src;
      end
    end
  end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
module tb_cmd_stream_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     s_valid;
  logic [N-1:0]     s_ready;
  logic [N*W-1:0]   s_data;
  logic [N-1:0]     s_last;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic             m_last;
  logic [1:0]       m_id;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_stream_arbiter #(.NUM_REQ(N), .FIFO_CMD_LENGTH(W)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_id(m_id)
  );

  always #5 clk = ~clk;

  // Reference model: burst ownership, fair pointer, and a single output slot.
  bit         mdl_locked = 0;
  int         mdl_owner  = 0;
  int         mdl_ptr    = 0;
  bit         mdl_mv     = 0;
  logic [7:0] mdl_md     = 0;
  bit         mdl_ml     = 0;
  int         mdl_mid    = 0;

  function automatic logic [N-1:0] model_ready();
    if (reset) return '0;
    if (mdl_mv && !m_ready) return '0;
    if (mdl_locked) return N'(1) << mdl_owner;
    for (int k = 0; k < N; k++)
      if (s_valid[(mdl_ptr + k) % N]) return N'(1) << ((mdl_ptr + k) % N);
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] hit;
    if (reset) begin
      mdl_locked = 0; mdl_owner = 0; mdl_ptr = 0;
      mdl_mv = 0; mdl_md = 0; mdl_ml = 0; mdl_mid = 0;
    end else if (!(mdl_mv && !m_ready)) begin
      hit = model_ready() & s_valid;
      mdl_mv = (hit != 0);
      for (int i = 0; i < N; i++) begin
        if (hit[i]) begin
          mdl_md  = s_data[i*W +: W];
          mdl_ml  = s_last[i];
          mdl_mid = i;
          if (s_last[i]) begin
            mdl_locked = 0;
            mdl_ptr    = (i + 1) % N;
          end else begin
            mdl_locked = 1;
            mdl_owner  = i;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [W-1:0] outq[$];
  logic [N-1:0] last_rdy;

  // Drive on the falling edge, check ready before the rising edge,
  // then check the registered outputs just after it.
  task automatic apply(input bit r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input bit mr, input logic [N*W-1:0] d);
    @(negedge clk);
    reset = r; s_valid = v; s_last = l; m_ready = mr; s_data = d;
    #1;
    last_rdy = s_ready;
    chk("s_ready", 32'(s_ready), 32'(model_ready()));
    if (m_valid && m_ready) outq.push_back(m_data);
    @(posedge clk);
    #1;
    chk("m_valid", 32'(m_valid), 32'(mdl_mv));
    if (mdl_mv) begin
      chk("m_data", 32'(m_data), 32'(mdl_md));
      chk("m_last", 32'(m_last), 32'(mdl_ml));
      chk("m_id",   32'(m_id),   32'(mdl_mid));
    end
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] v;
    logic [N-1:0] l;
    bit           mr;
    logic [N-1:0] exp_rdy;
    bit           exp_mv;
    int           exp_id;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1; s_valid = '0; s_last = '0; m_ready = 0; s_data = '0;

    // reset with everyone requesting, round-robin, burst lock, wrap
    tbl.push_back('{1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0});
    tbl.push_back('{1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3});
    tbl.push_back('{0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0});
    tbl.push_back('{0, 4'b0111, 4'b0000, 1, 4'b0010, 1, 1});
    tbl.push_back('{0, 4'b0111, 4'b0000, 1, 4'b0010, 1, 1});
    tbl.push_back('{0, 4'b0111, 4'b0010, 1, 4'b0010, 1, 1});
    tbl.push_back('{0, 4'b0101, 4'b0101, 1, 4'b0100, 1, 2});
    tbl.push_back('{0, 4'b1001, 4'b1001, 1, 4'b1000, 1, 3});
    tbl.push_back('{0, 4'b1001, 4'b1001, 1, 4'b0001, 1, 0});

    foreach (tbl[r]) begin
      apply(tbl[r].rst, tbl[r].v, tbl[r].l, tbl[r].mr, {4{8'(r)}} + 32'h30201000);
      chk("tbl_rdy", 32'(last_rdy), 32'(tbl[r].exp_rdy));
      chk("tbl_mv",  32'(m_valid),  32'(tbl[r].exp_mv));
      chk("tbl_id",  32'(m_id),     32'(tbl[r].exp_id));
      if (tbl[r].rst) chk("rst_data", 32'(m_data), 32'h0);
    end

    // Backpressure mid-burst from req0: A, B, C must come out once, in order.
    apply(0, 4'b0001, 4'b0000, 1, 32'h0000000A);
    outq.delete();
    chk("bp_first", 32'(m_data), 32'hA);
    for (int i = 0; i < 5; i++) begin
      apply(0, 4'b0001, 4'b0000, 0, 32'h0000000B);
      chk("bp_rdy",  32'(last_rdy), 32'h0);
      chk("bp_hold", 32'({m_valid, m_last, m_id, m_data}), 32'({1'b1, 1'b0, 2'd0, 8'hA}));
    end
    apply(0, 4'b0001, 4'b0000, 1, 32'h0000000B);
    apply(0, 4'b0001, 4'b0001, 1, 32'h0000000C);
    apply(0, 4'b0000, 4'b0000, 1, 32'h0);
    chk("bp_count", 32'(outq.size()), 32'd3);
    if (outq.size() == 3) begin
      chk("bp_seq0", 32'(outq[0]), 32'hA);
      chk("bp_seq1", 32'(outq[1]), 32'hB);
      chk("bp_seq2", 32'(outq[2]), 32'hC);
    end

    // Reset while req2 holds the lock: pointer returns to 0.
    apply(0, 4'b0100, 4'b0000, 1, 32'h44332211);
    chk("lk_id", 32'(m_id), 32'd2);
    apply(0, 4'b1111, 4'b0000, 1, 32'h44332211);
    chk("lk_rdy", 32'(last_rdy), 32'b0100);
    apply(1, 4'b1111, 4'b0000, 1, 32'h44332211);
    chk("rst_rdy", 32'(last_rdy), 32'h0);
    chk("rst_mv",  32'(m_valid), 32'h0);
    apply(0, 4'b1111, 4'b1111, 1, 32'h44332211);
    chk("post_rst_rdy", 32'(last_rdy), 32'b0001);
    chk("post_rst_id",  32'(m_id), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v, l;
      v = N'($urandom);
      for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 2) == 0);
      apply(($urandom_range(0, 199) == 0), v, l, ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
